// File: rtl/conv_window_scheduler_if.sv
// Handshake and line-buffer control bundle between the window scheduler
// and the pixel stream / pixel_buffer / convolution consumers.
interface conv_window_scheduler_if #(
    parameter int IMAGE_SIZE = 64
);
    localparam int AW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;

    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] buffer_wr_addr;
    logic [AW-1:0] buffer_rd_addr;
    logic          window_valid;
    logic [AW-1:0] out_row;
    logic [AW-1:0] out_col;
    logic          busy;
    logic          frame_done;

    modport master (
        input  start, in_valid,
        output in_ready, buffer_wr_addr, buffer_rd_addr, window_valid,
               out_row, out_col, busy, frame_done
    );

    modport slave (
        output start, in_valid,
        input  in_ready, buffer_wr_addr, buffer_rd_addr, window_valid,
               out_row, out_col, busy, frame_done
    );
endinterface

// File: rtl/conv_window_scheduler.sv
// Frame sequencer for one convolution layer: tracks raster position, drives
// shared line-buffer addresses and flags stride-aligned complete windows.
module conv_window_scheduler #(
    parameter int IMAGE_SIZE  = 64,
    parameter int FILTER_SIZE = 2,
    parameter int STRIDE      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    conv_window_scheduler_if.master bus
);
    localparam int AW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [AW-1:0] LAST    = AW'(IMAGE_SIZE - 1);
    localparam logic [AW-1:0] FM1     = AW'(FILTER_SIZE - 1);
    localparam logic [AW-1:0] RD_INIT = AW'((IMAGE_SIZE > 1) ? 1 : 0);
    localparam logic [PW-1:0] PLAST   = PW'(STRIDE - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] out_row_cnt;
    logic [AW-1:0] out_col_cnt;
    logic [PW-1:0] row_phase;
    logic [PW-1:0] col_phase;
    logic [AW-1:0] row_next;
    logic [AW-1:0] col_next;
    logic [PW-1:0] row_phase_next;
    logic [PW-1:0] col_phase_next;
    logic          accept;
    logic          col_wrap;
    logic          frame_end;
    logic          window_hit;

    assign accept              = bus.in_valid & bus.in_ready & clk_en;
    assign bus.buffer_wr_addr  = col;
    assign bus.buffer_rd_addr  = rd_addr;

    // Raster position and stride phase for the pixel after the current one;
    // phases count from the first column/row that can close a window.
    always_comb begin
        col_wrap  = (col == LAST);
        frame_end = col_wrap && (row == LAST);
        col_next  = col_wrap ? '0 : col + 1'b1;
        row_next  = row;
        if (frame_end)
            row_next = '0;
        else if (col_wrap)
            row_next = row + 1'b1;

        if (col_next <= FM1)
            col_phase_next = '0;
        else
            col_phase_next = (col_phase == PLAST) ? '0 : col_phase + 1'b1;

        row_phase_next = row_phase;
        if (col_wrap) begin
            if (row_next <= FM1)
                row_phase_next = '0;
            else
                row_phase_next = (row_phase == PLAST) ? '0 : row_phase + 1'b1;
        end

        window_hit = accept && (row >= FM1) && (col >= FM1) &&
                     (row_phase == '0) && (col_phase == '0);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else if (clk_en)
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        bus.in_ready   = 1'b0;
        bus.busy       = 1'b1;
        bus.frame_done = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start)
                    state_next = (FILTER_SIZE == 1) ? RUN : FILL;
            end
            FILL: begin
                bus.in_ready = 1'b1;
                if (accept && col_wrap && (row_next == FM1))
                    state_next = RUN;
            end
            RUN: begin
                bus.in_ready = 1'b1;
                if (accept && frame_end)
                    state_next = DONE;
            end
            DONE: begin
                bus.frame_done = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output coordinates come from running counters: out_col restarts each
    // row, out_row advances only after a row that produced windows.
    always_ff @(posedge clk) begin
        if (reset) begin
            row              <= '0;
            col              <= '0;
            row_phase        <= '0;
            col_phase        <= '0;
            rd_addr          <= RD_INIT;
            out_row_cnt      <= '0;
            out_col_cnt      <= '0;
            bus.window_valid <= 1'b0;
            bus.out_row      <= '0;
            bus.out_col      <= '0;
        end else if (clk_en) begin
            bus.window_valid <= window_hit;
            if (state == IDLE && bus.start) begin
                row         <= '0;
                col         <= '0;
                row_phase   <= '0;
                col_phase   <= '0;
                rd_addr     <= RD_INIT;
                out_row_cnt <= '0;
                out_col_cnt <= '0;
                bus.out_row <= '0;
                bus.out_col <= '0;
            end else if (accept) begin
                row       <= row_next;
                col       <= col_next;
                row_phase <= row_phase_next;
                col_phase <= col_phase_next;
                rd_addr   <= (rd_addr == LAST) ? '0 : rd_addr + 1'b1;
                if (window_hit) begin
                    bus.out_row <= out_row_cnt;
                    bus.out_col <= out_col_cnt;
                    out_col_cnt <= out_col_cnt + 1'b1;
                end
                if (col_wrap) begin
                    out_col_cnt <= '0;
                    if ((row >= FM1) && (row_phase == '0))
                        out_row_cnt <= out_row_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler on an 8x8 image: 3x3/stride 1,
// 3x3/stride 2 and 1x1 instances, checked against a division-based model.
module tb_conv_window_scheduler;
    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic clk_en   = 1'b1;
    logic start    = 1'b0;
    logic in_valid = 1'b0;
    int   sel      = 0;
    int   total    = 0;
    int   passed   = 0;

    logic       obs_ready, obs_wv, obs_busy, obs_done;
    logic [2:0] obs_wr, obs_rd, obs_row, obs_col;

    always #5 clk = ~clk;

    conv_window_scheduler_if #(.IMAGE_SIZE(8)) if_a (), if_b (), if_c ();

    assign if_a.start    = start && (sel == 0);
    assign if_a.in_valid = in_valid && (sel == 0);
    assign if_b.start    = start && (sel == 1);
    assign if_b.in_valid = in_valid && (sel == 1);
    assign if_c.start    = start && (sel == 2);
    assign if_c.in_valid = in_valid && (sel == 2);

    conv_window_scheduler #(.IMAGE_SIZE(8), .FILTER_SIZE(3), .STRIDE(1)) dut_a (
        .clk(clk), .reset(reset), .clk_en(clk_en), .bus(if_a));
    conv_window_scheduler #(.IMAGE_SIZE(8), .FILTER_SIZE(3), .STRIDE(2)) dut_b (
        .clk(clk), .reset(reset), .clk_en(clk_en), .bus(if_b));
    conv_window_scheduler #(.IMAGE_SIZE(8), .FILTER_SIZE(1), .STRIDE(1)) dut_c (
        .clk(clk), .reset(reset), .clk_en(clk_en), .bus(if_c));

    always_comb begin
        obs_ready = if_a.in_ready;
        obs_wv    = if_a.window_valid;
        obs_busy  = if_a.busy;
        obs_done  = if_a.frame_done;
        obs_wr    = if_a.buffer_wr_addr;
        obs_rd    = if_a.buffer_rd_addr;
        obs_row   = if_a.out_row;
        obs_col   = if_a.out_col;
        if (sel == 1) begin
            obs_ready = if_b.in_ready;
            obs_wv    = if_b.window_valid;
            obs_busy  = if_b.busy;
            obs_done  = if_b.frame_done;
            obs_wr    = if_b.buffer_wr_addr;
            obs_rd    = if_b.buffer_rd_addr;
            obs_row   = if_b.out_row;
            obs_col   = if_b.out_col;
        end else if (sel == 2) begin
            obs_ready = if_c.in_ready;
            obs_wv    = if_c.window_valid;
            obs_busy  = if_c.busy;
            obs_done  = if_c.frame_done;
            obs_wr    = if_c.buffer_wr_addr;
            obs_rd    = if_c.buffer_rd_addr;
            obs_row   = if_c.out_row;
            obs_col   = if_c.out_col;
        end
    end

    task automatic applyStimulus(input bit st, input bit iv);
        start    = st;
        in_valid = iv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, obs_ready, 0);
        checkOutput({tag, "_window_valid"}, obs_wv, 0);
        checkOutput({tag, "_frame_done"}, obs_done, 0);
        checkOutput({tag, "_busy"}, obs_busy, 0);
        checkOutput({tag, "_wr_addr"}, obs_wr, 0);
        checkOutput({tag, "_rd_addr"}, obs_rd, 1);
        checkOutput({tag, "_out_row"}, obs_row, 0);
        checkOutput({tag, "_out_col"}, obs_col, 0);
    endtask

    // One frame: k counts accepted pixels; expected windows come from the
    // closed-form (r-F+1)/S test rather than from phase counters.
    task automatic runFrame(input int filt, input int strd, input bit gaps,
                            input int gate_at, input int reset_at,
                            input int start_at, input int exp_windows);
        int k, cyc, r, c, windows, last_row, last_col;
        bit iv, exp_wv, last_wv, gated;
        k = 0; cyc = 0; windows = 0; gated = 0;
        last_wv = 0; last_row = 0; last_col = 0;
        applyStimulus(1, 0);
        checkOutput("start_busy", obs_busy, 1);
        checkOutput("start_ready", obs_ready, 1);
        checkOutput("start_window_valid", obs_wv, 0);
        while (k < 64 && cyc < 4000) begin
            r = k / 8;
            c = k % 8;
            if (k == reset_at) begin
                reset = 1'b1;
                applyStimulus(0, 1);
                reset = 1'b0;
                checkResetValues("mid_reset");
                applyStimulus(0, 1);
                checkOutput("after_reset_done", obs_done, 0);
                checkOutput("after_reset_busy", obs_busy, 0);
                checkOutput("after_reset_ready", obs_ready, 0);
                return;
            end
            if (k == gate_at && !gated) begin
                gated  = 1;
                clk_en = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    applyStimulus(0, 1);
                    checkOutput("gate_window_valid", obs_wv, last_wv);
                    checkOutput("gate_out_row", obs_row, last_row);
                    checkOutput("gate_out_col", obs_col, last_col);
                    checkOutput("gate_wr_addr", obs_wr, c);
                    checkOutput("gate_frame_done", obs_done, 0);
                end
                clk_en = 1'b1;
            end
            iv = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            checkOutput("ready", obs_ready, 1);
            checkOutput("wr_addr", obs_wr, c);
            checkOutput("rd_addr", obs_rd, (c + 1) % 8);
            applyStimulus(k == start_at, iv);
            exp_wv = iv && (r >= filt - 1) && (c >= filt - 1) &&
                     ((r - filt + 1) % strd == 0) && ((c - filt + 1) % strd == 0);
            checkOutput("window_valid", obs_wv, exp_wv);
            if (exp_wv) begin
                last_row = (r - filt + 1) / strd;
                last_col = (c - filt + 1) / strd;
                checkOutput("out_row", obs_row, last_row);
                checkOutput("out_col", obs_col, last_col);
            end
            last_wv = exp_wv;
            if (obs_wv) windows++;
            checkOutput("frame_done", obs_done, (iv && k == 63) ? 1 : 0);
            if (iv) k++;
            cyc++;
        end
        checkOutput("frame_accepts", k, 64);
        checkOutput("done_busy", obs_busy, 1);
        checkOutput("done_ready", obs_ready, 0);
        checkOutput("window_count", windows, exp_windows);
        applyStimulus(1, 1);
        checkOutput("post_busy", obs_busy, 0);
        checkOutput("post_ready", obs_ready, 0);
        checkOutput("post_window_valid", obs_wv, 0);
        checkOutput("post_frame_done", obs_done, 0);
        applyStimulus(0, 0);
        checkOutput("start_on_done_ignored", obs_busy, 0);
        checkOutput("post_wr_addr", obs_wr, 0);
        checkOutput("post_rd_addr", obs_rd, 1);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        reset = 1'b0;
        checkResetValues("reset");
        applyStimulus(0, 1);
        checkOutput("idle_ready", obs_ready, 0);
        checkOutput("idle_busy", obs_busy, 0);
        checkOutput("idle_wr_addr", obs_wr, 0);

        $display("[TB] 3x3 stride 1, continuous, start pulsed mid-frame");
        sel = 0; runFrame(3, 1, 0, -1, -1, 40, 36);
        $display("[TB] 3x3 stride 2");
        sel = 1; runFrame(3, 2, 0, -1, -1, -1, 9);
        $display("[TB] 3x3 stride 1 with random bubbles");
        sel = 0; runFrame(3, 1, 1, -1, -1, -1, 36);
        $display("[TB] 3x3 stride 1 with clk_en gated mid-row");
        sel = 0; runFrame(3, 1, 0, 29, -1, -1, 36);
        $display("[TB] reset at pixel (4,3) then full frame");
        sel = 0; runFrame(3, 1, 0, -1, 35, -1, 0);
        sel = 0; runFrame(3, 1, 0, -1, -1, -1, 36);
        $display("[TB] 1x1 filter");
        sel = 2; runFrame(1, 1, 0, -1, -1, 20, 64);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/conv_window_scheduler.md
# conv_window_scheduler

Frame-level sequencer for one convolution layer's pixel buffers. It accepts a raster-order pixel stream under a valid/ready handshake and tracks row and column. It drives the shared line-buffer write/read addresses for all `pixel_buffer` instances in the layer, and flags which cycles present a complete, stride-aligned FILTER_SIZE x FILTER_SIZE window to the downstream convolution unit. It also brackets each frame with start/busy/done control.

## Interface
- IMAGE_SIZE, 64, input image width and height in pixels (square); ≥ FILTER_SIZE.
- FILTER_SIZE, 2, kernel width and height; ≥ 1.
- STRIDE, 1, window step in both dimensions; ≥ 1.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; takes priority over clk_en.
- clk_en  in  1  global enable; when low, all state and outputs hold.
- start  in  1  begin a frame; sampled only in IDLE.
- in_valid  in  1  upstream pixel present this cycle.
- in_ready  out  1  scheduler can accept a pixel; high only in FILL and RUN.
- buffer_wr_addr  out  `LOG2(IMAGE_SIZE)  line-buffer write address = current column.
- buffer_rd_addr  out  `LOG2(IMAGE_SIZE)  line-buffer read address = (column+1) mod IMAGE_SIZE.
- window_valid  out  1  pixel buffers hold a valid window.
- out_row, out_col  out  `LOG2(IMAGE_SIZE) each  output-feature-map coordinate of the flagged window.
- busy  out  1  frame in progress (FILL, RUN or DONE).
- frame_done  out  1  one-cycle pulse marking the last window of the frame.

## Operation
- Accept = in_valid & in_ready & clk_en. Counters advance only on accept.
- States:
  - IDLE: in_ready=0. start → FILL, clearing row, col, phase counters and out_row/out_col.
  - FILL: row < FILTER_SIZE-1. Accepts pixels and no windows are possible. When the accept of (row FILTER_SIZE-2, col IMAGE_SIZE-1) occurs → RUN. If FILTER_SIZE=1, start goes straight to RUN.
  - RUN: row ≥ FILTER_SIZE-1. On accept of (IMAGE_SIZE-1, IMAGE_SIZE-1) → DONE.
  - DONE: in_ready=0, one cycle, then → IDLE.
- Column counter wraps IMAGE_SIZE-1 → 0 and increments row. The wrap is explicit and does not rely on power-of-two sizes.
- Stride alignment uses row/col phase counters (0..STRIDE-1), not division.
  - Column phase restarts at 0 when col = FILTER_SIZE-1 and on row wrap.
  - Row phase restarts at 0 when row = FILTER_SIZE-1.
- Window condition on the accept of pixel (r,c): r ≥ FILTER_SIZE-1, c ≥ FILTER_SIZE-1, and both phases are 0.
- Output coordinates are out_row = (r-FILTER_SIZE+1)/STRIDE and out_col = (c-FILTER_SIZE+1)/STRIDE. They are maintained as incrementing counters; out_col resets per row.
- Output map size is OUT = (IMAGE_SIZE-FILTER_SIZE)/STRIDE+1 per dimension, so OUT² windows per frame.
- Trailing columns or rows not reachable by a full stride step produce no window.
- start in any state other than IDLE is ignored. start on the same cycle as the DONE→IDLE transition is ignored.
- in_valid while in_ready=0 is not consumed; upstream holds it.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready, window_valid, frame_done, busy = 0.
  - buffer_wr_addr = 0, buffer_rd_addr = 1 mod IMAGE_SIZE.
  - out_row = out_col = 0.
- buffer_wr_addr and buffer_rd_addr are registered. During the accept cycle of pixel (r,c), buffer_wr_addr = c; the address updates the cycle after the accept.
- window_valid, out_row, out_col are registered and asserted in the cycle after the qualifying accept. This aligns with pixel_buffer output latency.
- window_valid is low on every cycle with no qualifying accept, including upstream bubbles.
- frame_done is high in the cycle after the final accept, the same cycle as the final window_valid. That cycle is the DONE state.
- busy rises the cycle after start and falls the cycle after DONE.
- clk_en low: no state, counter or output changes. window_valid and frame_done hold their level; downstream is gated by the same clk_en.
- reset mid-frame: next cycle is IDLE with all reset values. Partial-frame windows are discarded and no frame_done is produced.
- Minimum frame length with in_valid held high: IMAGE_SIZE² accept cycles, plus 1 DONE cycle, plus 1 start cycle.

## Test plan
- IMAGE_SIZE=8, FILTER_SIZE=3, STRIDE=1, continuous in_valid after start → exactly 36 window_valid pulses.
  - First pulse is the cycle after the 19th accept (pixel 2,2) with out_row=0, out_col=0.
  - Last pulse carries out 5,5 together with frame_done.
  - buffer_wr_addr cycles 0..7 eight times.
- Same sizes, STRIDE=2 → 9 windows at input pixels (2,2), (2,4), (2,6), (4,2), …, (6,6), with out coordinates 0..2 in both dimensions.
- Random in_valid gaps (~50%) → the same 36 windows in the same order, and window_valid is never high in a cycle following a non-accept.
- clk_en low for 5 cycles mid-row → all outputs frozen; the resumed stream matches the ungated window sequence exactly.
- reset asserted at pixel (4,3) → IDLE, all outputs at reset values next cycle, no frame_done. A following start produces a full correct frame.
- start pulsed during RUN and on the DONE cycle → ignored, with no counter disturbance. A frame with FILTER_SIZE=1 goes straight to RUN and yields 64 windows.
